// File: rtl/rx_deserializer.sv
// rx_deserializer: frames start bit, SBS code and payload chunks of serial-memory responses
// Ports:
//   clk, reset          clock, synchronous active-high reset
//   rx_pins             serial input, idle when rx_pins[0] is high
//   read_issued         pulse when a read command has been sent
//   rx_started          start bit accepted this cycle
//   rx_active           response in progress
//   rx_sbs/_valid       SBS code (live in SBS cycle, latched otherwise) and its strobe
//   rx_counter          payload chunk index
//   rx_data_valid/done  prefetch payload chunk strobe / last chunk
//   rd_data_valid/done  load-data payload chunk strobe / last chunk
//   outstanding         issued-but-unanswered read count
//   rx_error            spurious start bit or request overflow
module rx_deserializer #(
  parameter int IO_BITS = 2,
  parameter int PAYLOAD_CYCLES = 8,
  parameter int MAX_OUTSTANDING = 3,
  localparam int CW = $clog2(PAYLOAD_CYCLES) + 1,
  localparam int OW = $clog2(MAX_OUTSTANDING + 1)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [IO_BITS-1:0] rx_pins,
  input  logic               read_issued,
  output logic               rx_started,
  output logic               rx_active,
  output logic [IO_BITS-1:0] rx_sbs,
  output logic               rx_sbs_valid,
  output logic [CW-1:0]      rx_counter,
  output logic               rx_data_valid,
  output logic               rx_done,
  output logic               rd_data_valid,
  output logic               rd_done,
  output logic [OW-1:0]      outstanding,
  output logic               rx_error
);
  typedef enum logic [1:0] {IDLE, SBS, DATA} state_t;
  state_t state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [IO_BITS-1:0] sbs_q, sbs_d;
  logic [OW-1:0] out_q, out_d;
  logic start_bit, last, dec, ovf;
  always_comb begin
    start_bit = state_q == IDLE && !rx_pins[0];
    last = state_q == DATA && cnt_q == CW'(PAYLOAD_CYCLES - 1);
    // reserved SBS codes finish a response without retiring a request
    dec = last && sbs_q <= IO_BITS'(1) && out_q != '0;
    ovf = read_issued && !dec && out_q == OW'(MAX_OUTSTANDING);
    rx_started = start_bit && out_q != '0;
    rx_error = (start_bit && out_q == '0) || ovf;
    rx_active = state_q != IDLE;
    rx_sbs_valid = state_q == SBS;
    rx_sbs = rx_sbs_valid ? rx_pins : sbs_q;
    rx_counter = cnt_q;
    rx_data_valid = state_q == DATA && sbs_q == IO_BITS'(0);
    rd_data_valid = state_q == DATA && sbs_q == IO_BITS'(1);
    rx_done = rx_data_valid && last;
    rd_done = rd_data_valid && last;
    outstanding = out_q;
    state_d = state_q == IDLE ? (rx_started ? SBS : IDLE) : state_q == SBS ? DATA : (last ? IDLE : DATA);
    cnt_d = state_q == DATA && !last ? cnt_q + CW'(1) : '0;
    sbs_d = rx_sbs_valid ? rx_pins : sbs_q;
    out_d = read_issued && !dec && !ovf ? out_q + OW'(1) : dec && !read_issued ? out_q - OW'(1) : out_q;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q <= '0;
      sbs_q <= '0;
      out_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      sbs_q <= sbs_d;
      out_q <= out_d;
    end
  end
endmodule
